// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Arbitrates N_CLIENTS requesting modules onto the single memory_unit command
//   port. A winning client's command is latched on grant, issued to memory as a
//   one-cycle mem_execute pulse, tracked through the mem_ready handshake
//   (ready drops = accepted, ready rises = finished), and acknowledged to the
//   owner with a one-cycle done pulse. Only one transaction is ever in flight.
//   MODE=0 grants the client named by sel_in; MODE=1 rotates over req_execute.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active low
//   sel_in       owner index (MODE=0 only)
//   req_execute  per-client request, held until that client's done
//   req_func     per-client 2-bit func, client i at [2i+1:2i]
//   req_addr1    per-client address1, client i at [ADDR_W*i +: ADDR_W]
//   req_addr2    per-client address2, client i at [ADDR_W*i +: ADDR_W]
//   req_wdata    per-client write data, client i at [DATA_W*i +: DATA_W]
//   grant        one-hot, high from latch until the done cycle (inclusive)
//   done         one-cycle pulse to the owner when its transaction completes
//   owner        index of the current / last granted client
//   mem_func, mem_execute, mem_addr1, mem_addr2, mem_wdata   memory command
//   mem_ready    memory_unit is_ready
//   timeout_err  sticky; set when a transaction is abandoned, cleared by rst
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int N_CLIENTS = 5,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int SEL_W     = $clog2(N_CLIENTS),
   parameter int MODE      = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SEL_W-1:0]              sel_in,
   input  logic [N_CLIENTS-1:0]          req_execute,
   input  logic [2*N_CLIENTS-1:0]        req_func,
   input  logic [ADDR_W*N_CLIENTS-1:0]   req_addr1,
   input  logic [ADDR_W*N_CLIENTS-1:0]   req_addr2,
   input  logic [DATA_W*N_CLIENTS-1:0]   req_wdata,
   output logic [N_CLIENTS-1:0]          grant,
   output logic [N_CLIENTS-1:0]          done,
   output logic [SEL_W-1:0]              owner,
   output logic [1:0]                    mem_func,
   output logic                          mem_execute,
   output logic [ADDR_W-1:0]             mem_addr1,
   output logic [ADDR_W-1:0]             mem_addr2,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ready,
   output logic                          timeout_err
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   // One-hot decode of a client index.
   function automatic logic [N_CLIENTS-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [N_CLIENTS-1:0] v;
      v = {N_CLIENTS{1'b0}};
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (idx == SEL_W'(i)) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   // Round-robin successor: the client after p, wrapping at N_CLIENTS-1.
   function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
      if (p == SEL_W'(N_CLIENTS - 1)) begin
         return {SEL_W{1'b0}};
      end else begin
         return p + SEL_W'(1);
      end
   endfunction

   state_t               state_r, state_s;
   logic [N_CLIENTS-1:0] grant_r, grant_s;
   logic [N_CLIENTS-1:0] done_r, done_s;
   logic [SEL_W-1:0]     owner_r, owner_s;
   logic [1:0]           mem_func_r, mem_func_s;
   logic                 mem_execute_r, mem_execute_s;
   logic [ADDR_W-1:0]    mem_addr1_r, mem_addr1_s;
   logic [ADDR_W-1:0]    mem_addr2_r, mem_addr2_s;
   logic [DATA_W-1:0]    mem_wdata_r, mem_wdata_s;
   logic                 timeout_err_r, timeout_err_s;
   logic [SEL_W-1:0]     rr_ptr_r, rr_ptr_s;
   logic [7:0]           cnt_r, cnt_s;

   logic                 win_valid_s;
   logic [SEL_W-1:0]     win_idx_s;
   logic                 hi_hit_s, lo_hit_s;
   logic [SEL_W-1:0]     hi_idx_s, lo_idx_s;
   logic [1:0]           cand_func_s;
   logic [ADDR_W-1:0]    cand_addr1_s, cand_addr2_s;
   logic [DATA_W-1:0]    cand_wdata_s;
   logic [7:0]           cnt_inc_s;
   logic                 timeout_hit_s;

   // Winner selection evaluated every cycle; only consumed in IDLE.
   // Round-robin: lowest requester at or above rr_ptr, else lowest overall (wrap).
   always_comb begin
      win_valid_s = 1'b0;
      win_idx_s   = {SEL_W{1'b0}};
      hi_hit_s    = 1'b0;
      lo_hit_s    = 1'b0;
      hi_idx_s    = {SEL_W{1'b0}};
      lo_idx_s    = {SEL_W{1'b0}};
      if (MODE != 0) begin
         for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            if (req_execute[i]) begin
               lo_hit_s = 1'b1;
               lo_idx_s = SEL_W'(i);
               if (SEL_W'(i) >= rr_ptr_r) begin
                  hi_hit_s = 1'b1;
                  hi_idx_s = SEL_W'(i);
               end else begin
                  hi_hit_s = hi_hit_s;
               end
            end else begin
               lo_hit_s = lo_hit_s;
            end
         end
         win_valid_s = lo_hit_s;
         win_idx_s   = hi_hit_s ? hi_idx_s : lo_idx_s;
      end else begin
         // An out-of-range sel_in matches no client and so never wins.
         for (int i = 0; i < N_CLIENTS; i++) begin
            if ((sel_in == SEL_W'(i)) && req_execute[i]) begin
               win_valid_s = 1'b1;
               win_idx_s   = sel_in;
            end else begin
               win_valid_s = win_valid_s;
            end
         end
      end
   end

   // Extract the winner's command fields from the packed request buses.
   always_comb begin
      cand_func_s  = 2'b00;
      cand_addr1_s = {ADDR_W{1'b0}};
      cand_addr2_s = {ADDR_W{1'b0}};
      cand_wdata_s = {DATA_W{1'b0}};
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (win_idx_s == SEL_W'(i)) begin
            cand_func_s  = req_func[2*i +: 2];
            cand_addr1_s = req_addr1[ADDR_W*i +: ADDR_W];
            cand_addr2_s = req_addr2[ADDR_W*i +: ADDR_W];
            cand_wdata_s = req_wdata[DATA_W*i +: DATA_W];
         end else begin
            cand_func_s = cand_func_s;
         end
      end
   end

   // Saturating wait counter; timeout fires once TIMEOUT wait cycles have elapsed.
   always_comb begin
      cnt_inc_s     = (cnt_r == 8'hFF) ? 8'hFF : (cnt_r + 8'd1);
      timeout_hit_s = (32'(cnt_inc_s) == TIMEOUT);
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_s       = state_r;
      grant_s       = grant_r;
      done_s        = {N_CLIENTS{1'b0}};
      owner_s       = owner_r;
      mem_func_s    = mem_func_r;
      mem_execute_s = 1'b0;
      mem_addr1_s   = mem_addr1_r;
      mem_addr2_s   = mem_addr2_r;
      mem_wdata_s   = mem_wdata_r;
      timeout_err_s = timeout_err_r;
      rr_ptr_s      = rr_ptr_r;
      cnt_s         = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (mem_ready && win_valid_s) begin
               state_s       = ST_ISSUE;
               grant_s       = onehot(win_idx_s);
               owner_s       = win_idx_s;
               mem_func_s    = cand_func_s;
               mem_addr1_s   = cand_addr1_s;
               mem_addr2_s   = cand_addr2_s;
               mem_wdata_s   = cand_wdata_s;
               mem_execute_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s = ST_WAIT_ACK;
            cnt_s   = 8'd0;
         end
         ST_WAIT_ACK: begin
            cnt_s = cnt_inc_s;
            if (timeout_hit_s) begin
               state_s       = ST_DONE;
               timeout_err_s = 1'b1;
               done_s        = grant_r;
            end else if (!mem_ready) begin
               state_s = ST_WAIT_DONE;
            end else begin
               state_s = ST_WAIT_ACK;
            end
         end
         ST_WAIT_DONE: begin
            cnt_s = cnt_inc_s;
            if (timeout_hit_s) begin
               state_s       = ST_DONE;
               timeout_err_s = 1'b1;
               done_s        = grant_r;
            end else if (mem_ready) begin
               state_s = ST_DONE;
               done_s  = grant_r;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            grant_s = {N_CLIENTS{1'b0}};
            if (MODE != 0) begin
               rr_ptr_s = next_ptr(owner_r);
            end else begin
               rr_ptr_s = rr_ptr_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = {N_CLIENTS{1'b0}};
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         grant_r       <= {N_CLIENTS{1'b0}};
         done_r        <= {N_CLIENTS{1'b0}};
         owner_r       <= {SEL_W{1'b0}};
         mem_func_r    <= 2'b00;
         mem_execute_r <= 1'b0;
         mem_addr1_r   <= {ADDR_W{1'b0}};
         mem_addr2_r   <= {ADDR_W{1'b0}};
         mem_wdata_r   <= {DATA_W{1'b0}};
         timeout_err_r <= 1'b0;
         rr_ptr_r      <= {SEL_W{1'b0}};
         cnt_r         <= 8'd0;
      end else begin
         state_r       <= state_s;
         grant_r       <= grant_s;
         done_r        <= done_s;
         owner_r       <= owner_s;
         mem_func_r    <= mem_func_s;
         mem_execute_r <= mem_execute_s;
         mem_addr1_r   <= mem_addr1_s;
         mem_addr2_r   <= mem_addr2_s;
         mem_wdata_r   <= mem_wdata_s;
         timeout_err_r <= timeout_err_s;
         rr_ptr_r      <= rr_ptr_s;
         cnt_r         <= cnt_s;
      end
   end

   assign grant       = grant_r;
   assign done        = done_r;
   assign owner       = owner_r;
   assign mem_func    = mem_func_r;
   assign mem_execute = mem_execute_r;
   assign mem_addr1   = mem_addr1_r;
   assign mem_addr2   = mem_addr2_r;
   assign mem_wdata   = mem_wdata_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Two arbiter instances share one clock and reset: dut0 in owner-select mode
//   (MODE=0) and dut1 in round-robin mode (MODE=1). Each has a small memory
//   responder: after seeing mem_execute it drops mem_ready for cycles
//   1..rdy_lat-1, then raises it again. busy0 holds dut0's ready low,
//   no_ack0 holds it high (memory never accepts).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int N  = 5;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [SW-1:0]   sel0, sel1;
   logic [N-1:0]    req0, req1;
   logic [2*N-1:0]  func0, func1;
   logic [AW*N-1:0] a1_0, a2_0, a1_1, a2_1;
   logic [DW*N-1:0] wd0, wd1;
   logic [N-1:0]    grant0, done0, grant1, done1;
   logic [SW-1:0]   owner0, owner1;
   logic [1:0]      mfunc0, mfunc1;
   logic            mexec0, mexec1;
   logic [AW-1:0]   maddr1_0, maddr2_0, maddr1_1, maddr2_1;
   logic [DW-1:0]   mwd0, mwd1;
   logic            mready0, mready1, terr0, terr1;

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   mc0 = 0, mc1 = 0;
   int   rdy_lat0 = 3;
   int   rdy_lat1 = 3;
   logic busy0 = 1'b0;
   logic no_ack0 = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MODE(0), .TIMEOUT(255)) dut0 (
      .clk(clk), .rst(rst), .sel_in(sel0), .req_execute(req0), .req_func(func0),
      .req_addr1(a1_0), .req_addr2(a2_0), .req_wdata(wd0), .grant(grant0), .done(done0),
      .owner(owner0), .mem_func(mfunc0), .mem_execute(mexec0), .mem_addr1(maddr1_0),
      .mem_addr2(maddr2_0), .mem_wdata(mwd0), .mem_ready(mready0), .timeout_err(terr0));

   mem_port_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MODE(1), .TIMEOUT(255)) dut1 (
      .clk(clk), .rst(rst), .sel_in(sel1), .req_execute(req1), .req_func(func1),
      .req_addr1(a1_1), .req_addr2(a2_1), .req_wdata(wd1), .grant(grant1), .done(done1),
      .owner(owner1), .mem_func(mfunc1), .mem_execute(mexec1), .mem_addr1(maddr1_1),
      .mem_addr2(maddr2_1), .mem_wdata(mwd1), .mem_ready(mready1), .timeout_err(terr1));

   // Memory responder models
   always @(posedge clk or negedge rst) begin
      if (!rst) mc0 <= 0;
      else if (mexec0) mc0 <= 1;
      else if (mc0 != 0 && mc0 < rdy_lat0) mc0 <= mc0 + 1;
      else mc0 <= 0;
   end
   assign mready0 = no_ack0 ? 1'b1 : (busy0 ? 1'b0 : !(mc0 != 0 && mc0 < rdy_lat0));

   always @(posedge clk or negedge rst) begin
      if (!rst) mc1 <= 0;
      else if (mexec1) mc1 <= 1;
      else if (mc1 != 0 && mc1 < rdy_lat1) mc1 <= mc1 + 1;
      else mc1 <= 0;
   end
   assign mready1 = !(mc1 != 0 && mc1 < rdy_lat1);

   task automatic test_reset();
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++; if (grant0 !== 5'b00000) $display("FAIL rst_grant0: got %b want 00000", grant0); else pass_cnt++;
      total_cnt++; if (done0 !== 5'b00000) $display("FAIL rst_done0: got %b want 00000", done0); else pass_cnt++;
      total_cnt++; if (owner0 !== 3'd0) $display("FAIL rst_owner0: got %0d want 0", owner0); else pass_cnt++;
      total_cnt++; if (mexec0 !== 1'b0) $display("FAIL rst_exec0: got %b want 0", mexec0); else pass_cnt++;
      total_cnt++; if (maddr1_0 !== 16'h0000) $display("FAIL rst_addr1: got %h want 0000", maddr1_0); else pass_cnt++;
      total_cnt++; if (terr0 !== 1'b0) $display("FAIL rst_terr0: got %b want 0", terr0); else pass_cnt++;
      total_cnt++; if (grant1 !== 5'b00000) $display("FAIL rst_grant1: got %b want 00000", grant1); else pass_cnt++;
      total_cnt++; if (mfunc1 !== 2'b00) $display("FAIL rst_func1: got %b want 00", mfunc1); else pass_cnt++;
      rst = 1'b1;
   endtask

   // T1: one owner-select transaction, ack after 1 cycle, ready after 3.
   task automatic test_owner_select();
      int n_exec = 0, n_done = 0, exec_at = -1, done_at = -1;
      @(negedge clk);
      sel0 = 3'd2; req0 = 5'b00100;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mexec0) begin
            n_exec++;
            if (exec_at < 0) begin
               exec_at = c;
               total_cnt++; if (maddr1_0 !== 16'h0010) $display("FAIL t1_addr1: got %h want 0010", maddr1_0); else pass_cnt++;
               total_cnt++; if (maddr2_0 !== 16'h0202) $display("FAIL t1_addr2: got %h want 0202", maddr2_0); else pass_cnt++;
               total_cnt++; if (mwd0 !== 32'hA000_0002) $display("FAIL t1_wdata: got %h want a0000002", mwd0); else pass_cnt++;
               total_cnt++; if (mfunc0 !== 2'd1) $display("FAIL t1_func: got %0d want 1", mfunc0); else pass_cnt++;
               total_cnt++; if (grant0 !== 5'b00100) $display("FAIL t1_grant: got %b want 00100", grant0); else pass_cnt++;
               total_cnt++; if (owner0 !== 3'd2) $display("FAIL t1_owner: got %0d want 2", owner0); else pass_cnt++;
            end
         end
         if (done0 !== 5'b00000) begin
            n_done++;
            if (done_at < 0) done_at = c;
            total_cnt++; if (done0 !== 5'b00100) $display("FAIL t1_done_bits: got %b want 00100", done0); else pass_cnt++;
            req0 = 5'b00000;
         end
      end
      total_cnt++; if (n_exec !== 1) $display("FAIL t1_exec_count: got %0d want 1", n_exec); else pass_cnt++;
      total_cnt++; if (exec_at !== 1) $display("FAIL t1_exec_cycle: got %0d want 1", exec_at); else pass_cnt++;
      total_cnt++; if (n_done !== 1) $display("FAIL t1_done_count: got %0d want 1", n_done); else pass_cnt++;
      total_cnt++; if (done_at !== 5) $display("FAIL t1_done_cycle: got %0d want 5", done_at); else pass_cnt++;
      total_cnt++; if (grant0 !== 5'b00000) $display("FAIL t1_grant_clear: got %b want 00000", grant0); else pass_cnt++;
   endtask

   // T2: sel_in out of range with all requests high -> no activity for 50 cycles.
   task automatic test_out_of_range();
      int active = 0;
      sel0 = 3'd7; req0 = 5'b11111;
      repeat (50) begin
         @(negedge clk);
         if (mexec0 || (grant0 !== 5'b00000)) active++;
      end
      total_cnt++; if (active !== 0) $display("FAIL t2_no_grant: got %0d active cycles want 0", active); else pass_cnt++;
      req0 = 5'b00000;
   endtask

   // mem_ready low in IDLE blocks the grant; release lets it through next cycle.
   task automatic test_mem_busy();
      int active = 0, exec_at = -1, done_seen = 0;
      busy0 = 1'b1; sel0 = 3'd1; req0 = 5'b00010;
      repeat (10) begin
         @(negedge clk);
         if (mexec0 || (grant0 !== 5'b00000)) active++;
      end
      total_cnt++; if (active !== 0) $display("FAIL busy_no_grant: got %0d active cycles want 0", active); else pass_cnt++;
      busy0 = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mexec0 && exec_at < 0) begin
            exec_at = c;
            total_cnt++; if (maddr1_0 !== 16'h0101) $display("FAIL busy_addr1: got %h want 0101", maddr1_0); else pass_cnt++;
         end
         if (done0 !== 5'b00000 && done_seen == 0) begin
            done_seen = 1;
            total_cnt++; if (done0 !== 5'b00010) $display("FAIL busy_done: got %b want 00010", done0); else pass_cnt++;
            req0 = 5'b00000;
         end
      end
      total_cnt++; if (exec_at !== 1) $display("FAIL busy_exec_cycle: got %0d want 1", exec_at); else pass_cnt++;
      total_cnt++; if (done_seen !== 1) $display("FAIL busy_done_seen: got %0d want 1", done_seen); else pass_cnt++;
   endtask

   // T3: round-robin with all five requesting -> order 0..4,0..4.
   task automatic test_round_robin();
      logic [N-1:0] exp_oh;
      int got;
      req1 = 5'b11111;
      for (int t = 0; t < 10; t++) begin
         exp_oh = 5'b00001 << (t % 5);
         got = 0;
         for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (done1 !== 5'b00000) got = 1;
         end
         total_cnt++;
         if (got == 0) $display("FAIL t3_wait: no done for transaction %0d within 20 cycles", t);
         else pass_cnt++;
         total_cnt++; if (done1 !== exp_oh) $display("FAIL t3_order: txn %0d done %b want %b", t, done1, exp_oh); else pass_cnt++;
         total_cnt++; if (grant1 !== exp_oh) $display("FAIL t3_grant: txn %0d grant %b want %b", t, grant1, exp_oh); else pass_cnt++;
         if (t == 9) req1 = 5'b00000;
         @(negedge clk);
         total_cnt++; if (done1 !== 5'b00000) $display("FAIL t3_pulse_width: txn %0d done %b want 00000", t, done1); else pass_cnt++;
      end
   endtask

   // T4: bring rr_ptr to 3 via client 2, then req 00011 -> 0 (wrap) then 1.
   task automatic test_rr_wrap();
      logic [N-1:0] exp_list [3];
      int got;
      exp_list[0] = 5'b00100; exp_list[1] = 5'b00001; exp_list[2] = 5'b00010;
      req1 = 5'b00100;
      for (int t = 0; t < 3; t++) begin
         got = 0;
         for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            if (done1 !== 5'b00000) got = 1;
         end
         total_cnt++; if (done1 !== exp_list[t]) $display("FAIL t4_wrap: step %0d done %b want %b", t, done1, exp_list[t]); else pass_cnt++;
         if (t == 0) req1 = 5'b00011;
         if (t == 2) req1 = 5'b00000;
      end
   endtask

   // T5: memory never accepts. ISSUE at cycle 1, WAIT entered after it; the
   // 255th wait cycle ends on the edge that enters DONE, so both timeout_err
   // and done are first seen at sample 257.
   task automatic test_timeout();
      int err_at = -1, done_at = -1, n_exec = 0;
      no_ack0 = 1'b1; sel0 = 3'd3; req0 = 5'b01000;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (mexec0) n_exec++;
         if (terr0 && err_at < 0) err_at = c;
         if ((done0 !== 5'b00000) && done_at < 0) begin
            done_at = c;
            total_cnt++; if (done0 !== 5'b01000) $display("FAIL t5_done_bits: got %b want 01000", done0); else pass_cnt++;
            req0 = 5'b00000;
         end
      end
      total_cnt++; if (err_at !== 257) $display("FAIL t5_err_cycle: got %0d want 257", err_at); else pass_cnt++;
      total_cnt++; if (done_at !== 257) $display("FAIL t5_done_cycle: got %0d want 257", done_at); else pass_cnt++;
      total_cnt++; if (n_exec !== 1) $display("FAIL t5_exec_count: got %0d want 1", n_exec); else pass_cnt++;
      total_cnt++; if (terr0 !== 1'b1) $display("FAIL t5_sticky: got %b want 1", terr0); else pass_cnt++;
      no_ack0 = 1'b0;
   endtask

   // T6: async reset in WAIT_DONE, then normal operation (rr_ptr back to 0).
   task automatic test_reset_mid();
      int got = 0, n_done = 0, d0 = 0, d1 = 0;
      rdy_lat0 = 20; sel0 = 3'd4; req0 = 5'b10000;
      for (int c = 0; c < 10 && got == 0; c++) begin
         @(negedge clk);
         if (mexec0) got = 1;
      end
      total_cnt++; if (got !== 1) $display("FAIL t6_issue: got %0d want 1", got); else pass_cnt++;
      repeat (4) @(negedge clk);
      total_cnt++; if (grant0 !== 5'b10000) $display("FAIL t6_pre_grant: got %b want 10000", grant0); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++; if (grant0 !== 5'b00000) $display("FAIL t6_async_grant: got %b want 00000", grant0); else pass_cnt++;
      total_cnt++; if (owner0 !== 3'd0) $display("FAIL t6_async_owner: got %0d want 0", owner0); else pass_cnt++;
      total_cnt++; if (maddr1_0 !== 16'h0000) $display("FAIL t6_async_addr1: got %h want 0000", maddr1_0); else pass_cnt++;
      total_cnt++; if (mwd0 !== 32'h0000_0000) $display("FAIL t6_async_wdata: got %h want 00000000", mwd0); else pass_cnt++;
      total_cnt++; if (terr0 !== 1'b0) $display("FAIL t6_async_terr: got %b want 0", terr0); else pass_cnt++;
      repeat (3) begin
         @(negedge clk);
         if (done0 !== 5'b00000) n_done++;
      end
      total_cnt++; if (n_done !== 0) $display("FAIL t6_no_done: got %0d want 0", n_done); else pass_cnt++;
      rdy_lat0 = 3; req1 = 5'b10010; rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if ((done0 !== 5'b00000) && d0 == 0) begin
            d0 = 1;
            total_cnt++; if (done0 !== 5'b10000) $display("FAIL t6_regrant0: got %b want 10000", done0); else pass_cnt++;
            req0 = 5'b00000;
         end
         if ((done1 !== 5'b00000) && d1 == 0) begin
            d1 = 1;
            total_cnt++; if (done1 !== 5'b00010) $display("FAIL t6_rr_reset: got %b want 00010", done1); else pass_cnt++;
            req1 = 5'b00000;
         end
      end
      total_cnt++; if (d0 !== 1) $display("FAIL t6_done0_seen: got %0d want 1", d0); else pass_cnt++;
      total_cnt++; if (d1 !== 1) $display("FAIL t6_done1_seen: got %0d want 1", d1); else pass_cnt++;
   endtask

   initial begin
      sel0 = 3'd0; sel1 = 3'd0; req0 = 5'b00000; req1 = 5'b00000;
      for (int i = 0; i < N; i++) begin
         func0[2*i +: 2]   = 2'd3;
         a1_0[AW*i +: AW]  = 16'h0100 + 16'(i);
         a2_0[AW*i +: AW]  = 16'h0200 + 16'(i);
         wd0[DW*i +: DW]   = 32'hA000_0000 + 32'(i);
      end
      func0[2*2 +: 2]  = 2'd1;
      a1_0[AW*2 +: AW] = 16'h0010;
      func1 = func0; a1_1 = a1_0; a2_1 = a2_0; wd1 = wd0;

      test_reset();
      test_owner_select();
      test_out_of_range();
      test_mem_busy();
      test_round_robin();
      test_rr_wrap();
      test_timeout();
      test_reset_mid();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
